// File: rtl/layer_output_serializer.sv
// ============================================================================
// Module   : layer_output_serializer
// Brief    : Collects one layer's neuron activations and streams them, neuron 0
//            first, as the next layer's myinput/myinputValid word stream.
//            Optional argmax outputs enabled by macro SERIALIZER_ARGMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_output_serializer #(
   parameter int numNeurons = 30,
   parameter int dataWidth  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons*dataWidth-1:0] neuronOut,
   input  logic [numNeurons-1:0]           neuronValid,
   output logic [dataWidth-1:0]            outData,
   output logic                            outValid,
   output logic                            busy,
   output logic                            overrun
`ifdef SERIALIZER_ARGMAX_EN
   ,
   output logic [$clog2(numNeurons)-1:0]   maxIndex,
   output logic                            maxValid
`endif
);

   localparam int c_CW = $clog2(numNeurons);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(numNeurons - 1);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_SHIFT   = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_CW-1:0]       r_cnt;
   logic [dataWidth-1:0]  r_cap   [numNeurons];
   logic [dataWidth-1:0]  r_shift [numNeurons];
   logic [numNeurons-1:0] r_captured;

   logic w_complete;
   logic w_last;
   logic w_transfer;
   logic [dataWidth-1:0] w_word;

   assign w_complete = &(r_captured | neuronValid);
   assign w_last     = (r_state == ST_SHIFT) && (r_cnt == c_LAST);
   // A ready vector only moves into the shift bank when that bank is free:
   // while idle, or on the edge that emits the final word of the current one.
   assign w_transfer = w_complete && ((r_state == ST_COLLECT) || w_last);
   assign w_word     = r_shift[r_cnt];

   // outValid covers the final word, which is emitted after the FSM has
   // already returned to COLLECT.
   assign busy = (|r_captured) | (r_state == ST_SHIFT) | outValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_COLLECT;
         r_cnt      <= '0;
         r_captured <= '0;
         outData    <= '0;
         outValid   <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < numNeurons; i++) begin
            r_cap[i]   <= '0;
            r_shift[i] <= '0;
         end
      end else begin
         for (int i = 0; i < numNeurons; i++) begin
            if (w_transfer) begin
               r_shift[i]    <= neuronValid[i] ? neuronOut[i*dataWidth +: dataWidth] : r_cap[i];
               r_captured[i] <= 1'b0;
            end else if (neuronValid[i]) begin
               r_cap[i]      <= neuronOut[i*dataWidth +: dataWidth];
               r_captured[i] <= 1'b1;
            end
         end

         if (!w_transfer && |(neuronValid & r_captured)) begin
            overrun <= 1'b1;
         end

         case (r_state)
            ST_COLLECT: begin
               outValid <= 1'b0;
               if (w_transfer) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               outData  <= w_word;
               outValid <= 1'b1;
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= w_complete ? ST_SHIFT : ST_COLLECT;
               end else begin
                  r_cnt <= r_cnt + c_ONE;
               end
            end
            default: begin
               r_state  <= ST_COLLECT;
               outValid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SERIALIZER_ARGMAX_EN
   logic [dataWidth-1:0] r_run_max;
   logic [c_CW-1:0]      r_run_idx;
   logic                 r_done;

   // Strict greater-than keeps the lowest index on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_max <= '0;
         r_run_idx <= '0;
         r_done    <= 1'b0;
         maxIndex  <= '0;
         maxValid  <= 1'b0;
      end else begin
         r_done   <= w_last;
         maxValid <= r_done;
         if (r_done) begin
            maxIndex <= r_run_idx;
         end
         if (r_state == ST_SHIFT) begin
            if ((r_cnt == '0) || ($signed(w_word) > $signed(r_run_max))) begin
               r_run_max <= w_word;
               r_run_idx <= r_cnt;
            end
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
// ============================================================================
// Module   : tb_layer_output_serializer
// Brief    : Directed self-checking bench for layer_output_serializer (4 x 16),
//            argmax checks included when SERIALIZER_ARGMAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_output_serializer;

   localparam int c_N = 4;
   localparam int c_W = 16;

   logic             clk;
   logic             rst;
   logic [c_N*c_W-1:0] neuronOut;
   logic [c_N-1:0]   neuronValid;
   logic [c_W-1:0]   outData;
   logic             outValid;
   logic             busy;
   logic             overrun;
`ifdef SERIALIZER_ARGMAX_EN
   logic [1:0]       maxIndex;
   logic             maxValid;
`endif

   int n_checks;
   int n_errors;

   layer_output_serializer #(
      .numNeurons (c_N),
      .dataWidth  (c_W)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .neuronOut   (neuronOut),
      .neuronValid (neuronValid),
      .outData     (outData),
      .outValid    (outValid),
      .busy        (busy),
      .overrun     (overrun)
`ifdef SERIALIZER_ARGMAX_EN
      ,
      .maxIndex    (maxIndex),
      .maxValid    (maxValid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] mask, input logic [63:0] vec);
      neuronValid = mask;
      neuronOut   = vec;
      tick();
      neuronValid = '0;
   endtask

   task automatic expect_stream(input string tag, input logic [63:0] vec);
      for (int k = 0; k < c_N; k++) begin
         tick();
         check($sformatf("%s valid w%0d", tag, k), {31'd0, outValid}, 32'd1);
         check($sformatf("%s data w%0d", tag, k), {16'd0, outData}, {16'd0, vec[k*16 +: 16]});
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      neuronValid = '0;
      neuronOut   = '0;
      tick();
      tick();
      check("rst outValid", {31'd0, outValid}, 32'd0);
      check("rst outData", {16'd0, outData}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst overrun", {31'd0, overrun}, 32'd0);
`ifdef SERIALIZER_ARGMAX_EN
      check("rst maxValid", {31'd0, maxValid}, 32'd0);
      check("rst maxIndex", {30'd0, maxIndex}, 32'd0);
`endif
      rst = 1'b0;
      tick();

      // 1: all valids together
      present(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      check("t1 latency", {31'd0, outValid}, 32'd0);
      expect_stream("t1", {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      tick();
      check("t1 end valid", {31'd0, outValid}, 32'd0);
      check("t1 end busy", {31'd0, busy}, 32'd0);
      check("t1 overrun", {31'd0, overrun}, 32'd0);

      // 2: staggered valids, neuron1 last at cycle 9
      for (int c = 0; c < 10; c++) begin
         case (c)
            0: present(4'b0100, {16'h0000, 16'h0C22, 16'h0000, 16'h0000});
            3: present(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0A00});
            5: present(4'b1000, {16'h0D33, 16'h0000, 16'h0000, 16'h0000});
            9: present(4'b0010, {16'h0000, 16'h0000, 16'h0B11, 16'h0000});
            default: tick();
         endcase
         check($sformatf("t2 busy c%0d", c), {31'd0, busy}, 32'd1);
         check($sformatf("t2 idle c%0d", c), {31'd0, outValid}, 32'd0);
      end
      expect_stream("t2", {16'h0D33, 16'h0C22, 16'h0B11, 16'h0A00});
      check("t2 busy last", {31'd0, busy}, 32'd1);
      tick();
      check("t2 busy after", {31'd0, busy}, 32'd0);
      check("t2 end valid", {31'd0, outValid}, 32'd0);

      // 3: second vector arrives mid-stream, streams back-to-back
      present(4'b1111, {16'h1004, 16'h1003, 16'h1002, 16'h1001});
      tick();
      check("t3 a w0", {16'd0, outData}, 32'h1001);
      tick();
      check("t3 a w1", {16'd0, outData}, 32'h1002);
      neuronValid = 4'b1111;
      neuronOut   = {16'h2004, 16'h2003, 16'h2002, 16'h2001};
      tick();
      neuronValid = '0;
      check("t3 a w2", {16'd0, outData}, 32'h1003);
      tick();
      check("t3 a w3", {16'd0, outData}, 32'h1004);
      check("t3 a w3 valid", {31'd0, outValid}, 32'd1);
      expect_stream("t3 b", {16'h2004, 16'h2003, 16'h2002, 16'h2001});
      tick();
      check("t3 end valid", {31'd0, outValid}, 32'd0);
      check("t3 overrun", {31'd0, overrun}, 32'd0);

      // 4: double pulse on neuron1 before completion
      present(4'b0010, {16'h0000, 16'h0000, 16'h0011, 16'h0000});
      check("t4 no overrun yet", {31'd0, overrun}, 32'd0);
      present(4'b0010, {16'h0000, 16'h0000, 16'h0022, 16'h0000});
      check("t4 overrun set", {31'd0, overrun}, 32'd1);
      present(4'b1101, {16'h0400, 16'h0300, 16'h0000, 16'h0100});
      expect_stream("t4", {16'h0400, 16'h0300, 16'h0022, 16'h0100});
      tick();
      check("t4 overrun sticky", {31'd0, overrun}, 32'd1);

      // 5: async reset during word 2
      present(4'b1111, {16'h3004, 16'h3003, 16'h3002, 16'h3001});
      tick();
      tick();
      tick();
      check("t5 w2", {16'd0, outData}, 32'h3003);
      #2;
      rst = 1'b1;
      #1;
      check("t5 async valid", {31'd0, outValid}, 32'd0);
      check("t5 async overrun", {31'd0, overrun}, 32'd0);
      check("t5 async busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("t5 no resume", {31'd0, outValid}, 32'd0);
      present(4'b1111, {16'h4004, 16'h4003, 16'h4002, 16'h4001});
      expect_stream("t5", {16'h4004, 16'h4003, 16'h4002, 16'h4001});
      tick();
      check("t5 end valid", {31'd0, outValid}, 32'd0);

`ifdef SERIALIZER_ARGMAX_EN
      // 6: signed argmax, tie resolves to lowest index
      present(4'b1111, {16'h0100, 16'h7000, 16'hFFFF, 16'h7000});
      for (int k = 0; k < c_N; k++) begin
         tick();
         check($sformatf("t6 no pulse w%0d", k), {31'd0, maxValid}, 32'd0);
      end
      tick();
      check("t6 maxValid", {31'd0, maxValid}, 32'd1);
      check("t6 maxIndex", {30'd0, maxIndex}, 32'd0);
      tick();
      check("t6 pulse width", {31'd0, maxValid}, 32'd0);
      check("t6 index held", {30'd0, maxIndex}, 32'd0);

      present(4'b1111, {16'hFFFF, 16'h8001, 16'hFFFE, 16'h8000});
      expect_stream("t6b", {16'hFFFF, 16'h8001, 16'hFFFE, 16'h8000});
      tick();
      check("t6b maxValid", {31'd0, maxValid}, 32'd1);
      check("t6b maxIndex", {30'd0, maxIndex}, 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
